// File: rtl/model_matrix_transpose.sv
// Stream-in / stream-out matrix transpose: buffers a row-major SIZE_I x SIZE_J operand and replays it column-major.
// Optional output back-pressure port DATA_OUT_STALL is enabled by defining MODEL_MATRIX_TRANSPOSE_STALL_EN.
//
// state   | meaning
// STARTER | idle, waiting for START; size check and READY pulse for illegal sizes
// INPUT   | accepting elements row-major into the buffer
// OUTPUT  | emitting one element per cycle in transposed order
module model_matrix_transpose #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_ELEMENTS = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    DATA_IN_I_ENABLE,
  input  logic                    DATA_IN_J_ENABLE,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
`ifdef MODEL_MATRIX_TRANSPOSE_STALL_EN
  input  logic                    DATA_OUT_STALL,
`endif
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam int AW = $clog2(MAX_ELEMENTS);
  localparam logic [CONTROL_SIZE-1:0] ONE     = CONTROL_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] MAX_ELM = CONTROL_SIZE'(MAX_ELEMENTS);

  typedef enum logic [1:0] {
    STARTER = 2'd0,
    INPUT   = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t                  state;
  logic [CONTROL_SIZE-1:0] size_i;
  logic [CONTROL_SIZE-1:0] size_j;
  logic [CONTROL_SIZE-1:0] idx_i;
  logic [CONTROL_SIZE-1:0] idx_j;
  logic [DATA_SIZE-1:0]    buffer [MAX_ELEMENTS];

  logic [CONTROL_SIZE-1:0] addr_full;
  logic [AW-1:0]           addr;
  logic                    unused_addr_hi;
  logic                    last_i;
  logic                    last_j;
  logic                    in_valid;
  logic                    size_legal;
  logic                    stall;

`ifdef MODEL_MATRIX_TRANSPOSE_STALL_EN
  assign stall = DATA_OUT_STALL;
`else
  assign stall = 1'b0;
`endif

  assign addr_full      = idx_i * size_j + idx_j;
  assign addr           = addr_full[AW-1:0];
  assign unused_addr_hi = ^addr_full[CONTROL_SIZE-1:AW];
  assign last_i         = (idx_i == size_i - ONE);
  assign last_j         = (idx_j == size_j - ONE);
  assign in_valid       = DATA_IN_I_ENABLE | DATA_IN_J_ENABLE;

  // Bounding each dimension first keeps the product from wrapping into a small legal-looking value.
  always_comb begin
    size_legal = 1'b1;
    if (SIZE_I_IN == '0 || SIZE_J_IN == '0)
      size_legal = 1'b0;
    else if (SIZE_I_IN > MAX_ELM || SIZE_J_IN > MAX_ELM)
      size_legal = 1'b0;
    else if (SIZE_I_IN * SIZE_J_IN > MAX_ELM)
      size_legal = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (state == INPUT && in_valid)
      buffer[addr] <= DATA_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state             <= STARTER;
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT          <= '0;
      size_i            <= '0;
      size_j            <= '0;
      idx_i             <= '0;
      idx_j             <= '0;
    end else begin
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      case (state)
        STARTER: begin
          if (START) begin
            size_i <= SIZE_I_IN;
            size_j <= SIZE_J_IN;
            idx_i  <= '0;
            idx_j  <= '0;
            if (size_legal)
              state <= INPUT;
            else
              READY <= 1'b1;
          end
        end
        INPUT: begin
          if (in_valid) begin
            if (last_i && last_j) begin
              idx_i <= '0;
              idx_j <= '0;
              state <= OUTPUT;
            end else if (last_j) begin
              idx_j <= '0;
              idx_i <= idx_i + ONE;
            end else begin
              idx_j <= idx_j + ONE;
            end
          end
        end
        OUTPUT: begin
          // A stalled cycle holds indices and DATA_OUT and emits nothing.
          if (!stall) begin
            DATA_OUT          <= buffer[addr];
            DATA_OUT_J_ENABLE <= 1'b1;
            DATA_OUT_I_ENABLE <= (idx_i == '0);
            if (last_i && last_j) begin
              READY <= 1'b1;
              idx_i <= '0;
              idx_j <= '0;
              state <= STARTER;
            end else if (last_i) begin
              idx_i <= '0;
              idx_j <= idx_j + ONE;
            end else begin
              idx_i <= idx_i + ONE;
            end
          end
        end
        default: state <= STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_model_matrix_transpose.sv
// Self-checking bench for model_matrix_transpose: directed and randomized matrices against a transpose reference model.
module tb_model_matrix_transpose;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY;
  logic        DATA_IN_I_ENABLE;
  logic        DATA_IN_J_ENABLE;
  logic        DATA_OUT_I_ENABLE;
  logic        DATA_OUT_J_ENABLE;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic [63:0] DATA_IN;
  logic [63:0] DATA_OUT;
`ifdef MODEL_MATRIX_TRANSPOSE_STALL_EN
  logic        DATA_OUT_STALL = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] din [64];

  model_matrix_transpose dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .DATA_IN_I_ENABLE(DATA_IN_I_ENABLE), .DATA_IN_J_ENABLE(DATA_IN_J_ENABLE),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
`ifdef MODEL_MATRIX_TRANSPOSE_STALL_EN
    .DATA_OUT_STALL(DATA_OUT_STALL),
`endif
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_jen"}, {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
    check({tag, "_ien"}, {63'd0, DATA_OUT_I_ENABLE}, 64'd0);
    check({tag, "_ready"}, {63'd0, READY}, 64'd0);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) din[k] = {$urandom, $urandom};
  endtask

  task automatic start_run(input int ni, input int nj);
    SIZE_I_IN = 64'(ni);
    SIZE_J_IN = 64'(nj);
    START = 1'b1;
    tick();
    START = 1'b0;
    SIZE_I_IN = {$urandom, $urandom};
    SIZE_J_IN = {$urandom, $urandom};
  endtask

  task automatic feed(input logic [63:0] value, input bit row_start);
    DATA_IN = value;
    if (row_start) begin
      DATA_IN_I_ENABLE = 1'b1;
      DATA_IN_J_ENABLE = 1'($urandom_range(0, 1));
    end else begin
      DATA_IN_I_ENABLE = 1'b0;
      DATA_IN_J_ENABLE = 1'b1;
    end
    tick();
    DATA_IN_I_ENABLE = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    DATA_IN = {$urandom, $urandom};
  endtask

  // Reference: output k walks columns outer, rows inner, reading the row-major input.
  task automatic run_matrix(input int ni, input int nj, input bit gaps, input string tag);
    logic [63:0] exp_d [$];
    bit          exp_i [$];
    int n = ni * nj;
    for (int c = 0; c < nj; c++)
      for (int r = 0; r < ni; r++) begin
        exp_d.push_back(din[r * nj + c]);
        exp_i.push_back(r == 0);
      end
    start_run(ni, nj);
    check({tag, "_start_ready"}, {63'd0, READY}, 64'd0);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          DATA_IN = {$urandom, $urandom};
          START = 1'($urandom_range(0, 1));
          tick();
          check({tag, "_gap_jen"}, {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
        end
      end
      START = 1'($urandom_range(0, 1));
      feed(din[k], (k % nj) == 0);
      check({tag, "_in_jen"}, {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
    end
    START = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s_data%0d", tag, k), DATA_OUT, exp_d[k]);
      check($sformatf("%s_ien%0d", tag, k), {63'd0, DATA_OUT_I_ENABLE}, {63'd0, exp_i[k]});
      check($sformatf("%s_jen%0d", tag, k), {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
      check($sformatf("%s_ready%0d", tag, k), {63'd0, READY}, {63'd0, k == n - 1});
    end
    tick();
    check_idle({tag, "_after"});
  endtask

  task automatic run_illegal(input logic [63:0] si, input logic [63:0] sj, input string tag);
    SIZE_I_IN = si;
    SIZE_J_IN = sj;
    START = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_ready"}, {63'd0, READY}, 64'd1);
    check({tag, "_jen"}, {63'd0, DATA_OUT_J_ENABLE}, 64'd0);
    tick();
    check_idle({tag, "_next"});
  endtask

  initial begin
    RST = 1'b0;
    START = 1'b0;
    DATA_IN_I_ENABLE = 1'b0;
    DATA_IN_J_ENABLE = 1'b0;
    SIZE_I_IN = '0;
    SIZE_J_IN = '0;
    DATA_IN = '0;
    #1;
    check_idle("reset");
    check("reset_data", DATA_OUT, 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    tick();

    din[0] = 1; din[1] = 2; din[2] = 3; din[3] = 4; din[4] = 5; din[5] = 6;
    run_matrix(2, 3, 1'b0, "m2x3");

    din[0] = 64'hA5;
    run_matrix(1, 1, 1'b0, "m1x1");

    run_illegal(64'd0, 64'd5, "zero_i");
    run_illegal(64'd4, 64'd0, "zero_j");
    run_illegal(64'd9, 64'd8, "m9x8");
    run_illegal(64'd65, 64'd1, "m65x1");
    run_illegal(64'h1_0000_0000, 64'h1_0000_0000, "wrap");

    din[0] = 7; din[1] = 8; din[2] = 9; din[3] = 10;
    run_matrix(2, 2, 1'b1, "gaps2x2");

    fill_random(64); run_matrix(8, 8, 1'b1, "r8x8");
    fill_random(64); run_matrix(1, 64, 1'b0, "r1x64");
    fill_random(64); run_matrix(64, 1, 1'b0, "r64x1");
    for (int t = 0; t < 4; t++) begin
      int ni = $urandom_range(1, 8);
      int nj = $urandom_range(1, 8);
      fill_random(ni * nj);
      run_matrix(ni, nj, 1'b1, $sformatf("rnd%0d", t));
    end

    // Reset after 3 of 4 inputs aborts without READY.
    start_run(2, 2);
    feed(64'd11, 1'b1); feed(64'd12, 1'b0); feed(64'd13, 1'b1);
    RST = 1'b0;
    #1;
    check_idle("rst_in");
    check("rst_in_data", DATA_OUT, 64'd0);
    tick();
    RST = 1'b1;
    tick();
    check_idle("rst_in_post");

    // Reset in the middle of the output burst clears outputs immediately.
    start_run(2, 2);
    feed(64'd21, 1'b1); feed(64'd22, 1'b0); feed(64'd23, 1'b1); feed(64'd24, 1'b0);
    tick();
    check("rst_out_first", DATA_OUT, 64'd21);
    RST = 1'b0;
    #1;
    check_idle("rst_out");
    check("rst_out_data", DATA_OUT, 64'd0);
    tick();
    RST = 1'b1;
    tick();
    check_idle("rst_out_post");

    din[0] = 1; din[1] = 2; din[2] = 3; din[3] = 4;
    run_matrix(2, 2, 1'b0, "post_rst");

`ifdef MODEL_MATRIX_TRANSPOSE_STALL_EN
    start_run(2, 2);
    feed(64'd1, 1'b1); feed(64'd2, 1'b0); feed(64'd3, 1'b1); feed(64'd4, 1'b0);
    tick();
    check("stall_d0", DATA_OUT, 64'd1);
    check("stall_j0", {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
    DATA_OUT_STALL = 1'b1;
    tick();
    check_idle("stall_gap0");
    check("stall_hold0", DATA_OUT, 64'd1);
    tick();
    check_idle("stall_gap1");
    DATA_OUT_STALL = 1'b0;
    tick();
    check("stall_d1", DATA_OUT, 64'd3);
    check("stall_j1", {63'd0, DATA_OUT_J_ENABLE}, 64'd1);
    tick();
    check("stall_d2", DATA_OUT, 64'd2);
    check("stall_i2", {63'd0, DATA_OUT_I_ENABLE}, 64'd1);
    tick();
    check("stall_d3", DATA_OUT, 64'd4);
    check("stall_r3", {63'd0, READY}, 64'd1);
    tick();
    check_idle("stall_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
